shift_add_multiplier: RTL and testbench

- Unsigned sequential multiplier, radix-2 shift-and-add, one partial product per clock.
- Each iteration's addition uses a fulladder_chain instance; this block drives that chain's operands and consumes its sum and carry-out.
- Sits between operand producers and wider arithmetic datapaths that need a 2*WIDTH product without a combinational array multiplier.

---
 rtl/arith_pkg.sv | 15 +
 rtl/fulladder_chain.sv | 23 ++
 rtl/shift_add_multiplier.sv | 86 ++++++++
 tb/tb_shift_add_multiplier.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/arith_pkg.sv
// Shared arithmetic definitions: multiplier FSM states and counter sizing helper.
package arith_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mul_state_t;

    // One extra bit so the iteration counter can represent WIDTH without wrapping.
    function automatic int unsigned cnt_width(input int unsigned w);
        return int'($clog2(w)) + 1;
    endfunction

endpackage

// File: rtl/fulladder_chain.sv
// Ripple-carry chain of full adders; carry-out exposed so no sum bit is lost.
module fulladder_chain #(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out
);

    logic [WIDTH:0] carry;

    assign carry[0] = carry_in;

    for (genvar i = 0; i < WIDTH; i++) begin : g_fa
        assign sum[i]       = a[i] ^ b[i] ^ carry[i];
        assign carry[i + 1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end

    assign carry_out = carry[WIDTH];

endmodule

// File: rtl/shift_add_multiplier.sv
// Unsigned radix-2 shift-and-add multiplier: one partial product per clock, 2*WIDTH-bit result.
module shift_add_multiplier
    import arith_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int unsigned CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

    mul_state_t         state;
    logic [WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]   hi;
    logic [WIDTH-1:0]   lo;
    logic [CW-1:0]      iter;

    logic [WIDTH-1:0]   addend;
    logic [WIDTH-1:0]   sum;
    logic               carry;
    logic [WIDTH-1:0]   hi_next;
    logic [WIDTH-1:0]   lo_next;

    assign addend = lo[0] ? mcand : '0;

    fulladder_chain #(
        .WIDTH(WIDTH)
    ) u_chain (
        .a         (hi),
        .b         (addend),
        .carry_in  (1'b0),
        .sum       (sum),
        .carry_out (carry)
    );

    // {carry, sum, lo[WIDTH-1:1]} is the 2*WIDTH+1-bit partial result already shifted right by one.
    assign hi_next = {carry, sum[WIDTH-1:1]};
    assign lo_next = {sum[0], lo[WIDTH-1:1]};

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            mcand   <= '0;
            hi      <= '0;
            lo      <= '0;
            iter    <= '0;
            product <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        mcand <= a;
                        hi    <= '0;
                        lo    <= b;
                        iter  <= '0;
                        state <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    hi   <= hi_next;
                    lo   <= lo_next;
                    iter <= iter + CW'(1);
                    if (iter == LAST_ITER) begin
                        state   <= DONE;
                        product <= {hi_next, lo_next};
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Self-checking bench: directed cases with literal products plus randomized traffic against a countdown model.
module tb_shift_add_multiplier;

    localparam int unsigned W = 8;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic           start = 1'b0;
    logic [W-1:0]   a = '0;
    logic [W-1:0]   b = '0;
    logic           busy;
    logic           done;
    logic [2*W-1:0] product;

    int checks = 0;
    int failures = 0;
    bit chk_en = 1'b0;

    shift_add_multiplier #(.WIDTH(W)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    always #5 clk = ~clk;

    // Behavioural model: an accepted request finishes W cycles later with a*b.
    int             remaining = 0;
    logic [W-1:0]   ma = '0;
    logic [W-1:0]   mb = '0;
    logic           e_done = 1'b0;
    logic [2*W-1:0] e_prod = '0;

    always @(posedge clk) begin
        if (reset) begin
            remaining = 0;
            e_done    = 1'b0;
            e_prod    = '0;
        end else if (remaining > 0) begin
            remaining--;
            if (remaining == 0) begin
                e_done = 1'b1;
                e_prod = {{W{1'b0}}, ma} * {{W{1'b0}}, mb};
            end
        end else begin
            e_done = 1'b0;
            if (start) begin
                ma        = a;
                mb        = b;
                remaining = W;
            end
        end
    end

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy", longint'(busy), longint'(remaining > 0));
            chk("done", longint'(done), longint'(e_done));
            chk("product", longint'(product), longint'(e_prod));
        end
    end

    // Waits for done with a cycle budget; lat = negedges from the start-drive edge, -1 on timeout.
    task automatic wait_done(output int lat, output int busy_cycles);
        lat = -1;
        busy_cycles = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (busy) busy_cycles++;
            if (done) begin
                lat = i;
                break;
            end
        end
        if (lat < 0) chk("done_timeout", 0, 1);
    endtask

    task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y,
                          input longint exp, input string name);
        int lat, bc;
        @(negedge clk);
        a = x; b = y; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 1; bc = busy ? 1 : 0;
        if (!done) begin
            int l2, b2;
            wait_done(l2, b2);
            lat = (l2 < 0) ? -1 : l2 + 1;
            bc += b2;
        end
        chk({name, "_latency"}, lat, W + 1);
        chk({name, "_busy_cycles"}, bc, W);
        chk({name, "_product"}, longint'(product), exp);
    endtask

    initial begin
        int lat, bc, ndone;

        repeat (2) @(negedge clk);
        reset = 1'b0;
        chk_en = 1'b1;
        chk("reset_busy", longint'(busy), 0);
        chk("reset_done", longint'(done), 0);
        chk("reset_product", longint'(product), 0);

        run_op(8'd13, 8'd11, 143, "basic");
        run_op(8'd255, 8'd255, 65025, "max");
        run_op(8'd0, 8'd200, 0, "zero_a");
        run_op(8'd200, 8'd0, 0, "zero_b");
        repeat (3) @(negedge clk);
        chk("held_product", longint'(product), 0);
        run_op(8'd7, 8'd9, 63, "seven_nine");
        repeat (4) @(negedge clk);
        chk("held_product2", longint'(product), 63);

        // Start pulse during RUN must be ignored.
        @(negedge clk);
        a = 8'd6; b = 8'd7; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        a = 8'd100; b = 8'd100; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(lat, bc);
        chk("ignore_product", longint'(product), 42);
        ndone = 0;
        repeat (15) begin
            @(negedge clk);
            if (done) ndone++;
        end
        chk("ignore_extra_done", ndone, 0);

        // Reset mid-operation aborts with no done pulse.
        @(negedge clk);
        a = 8'd9; b = 8'd9; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort_busy", longint'(busy), 0);
        chk("abort_product", longint'(product), 0);
        ndone = 0;
        repeat (12) begin
            @(negedge clk);
            if (done) ndone++;
        end
        chk("abort_no_done", ndone, 0);
        run_op(8'd3, 8'd5, 15, "after_abort");

        // Back-to-back with start held high.
        @(negedge clk);
        a = 8'd2; b = 8'd3; start = 1'b1;
        wait_done(lat, bc);
        chk("b2b_first", longint'(product), 6);
        a = 8'd4; b = 8'd5;
        @(negedge clk);
        start = 1'b0;
        wait_done(lat, bc);
        chk("b2b_spacing", lat + 1, W + 1);
        chk("b2b_second", longint'(product), 20);

        // Randomized traffic, including operand churn during RUN and sporadic resets.
        for (int n = 0; n < 800; n++) begin
            @(negedge clk);
            case ($urandom_range(0, 3))
                0:       a = '0;
                1:       a = '1;
                default: a = W'($urandom);
            endcase
            case ($urandom_range(0, 3))
                0:       b = '0;
                1:       b = '1;
                default: b = W'($urandom);
            endcase
            start = ($urandom_range(0, 2) == 0);
            reset = ($urandom_range(0, 60) == 0);
        end
        @(negedge clk);
        start = 1'b0;
        reset = 1'b0;
        repeat (W + 3) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
